branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: combinational take decision, registered one-cycle PC redirect (1-cycle latency).
// No backpressure; branches landing in the flush shadow (SH_CNT>1) are dropped as squashed instructions.
module branch_resolver #(
   parameter int PC_W = 10
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            BR_VALID,
   input  logic [2:0]      BR_TYPE,
   input  logic [PC_W-1:0] BR_TARGET,
   input  logic [PC_W-1:0] RET_ADDR,
   input  logic            C_FLAG,
   input  logic            Z_FLAG,
   input  logic            FLG_LD_WB,
   input  logic            C_WB,
   input  logic            Z_WB,
   output logic            UNCON_BRN,
   output logic            TAKE_COND_BRN,
   output logic            PC_LD,
   output logic [PC_W-1:0] PC_TARGET,
   output logic            SHADOW,
   output logic [7:0]      TAKEN_CNT
);

   localparam logic [2:0] T_NONE = 3'b000;
   localparam logic [2:0] T_BRN  = 3'b001;
   localparam logic [2:0] T_BREQ = 3'b010;
   localparam logic [2:0] T_BRNE = 3'b011;
   localparam logic [2:0] T_BRCS = 3'b100;
   localparam logic [2:0] T_BRCC = 3'b101;
   localparam logic [2:0] T_CALL = 3'b110;
   localparam logic [2:0] T_RET  = 3'b111;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t          state_q;
   logic [2:0]      sh_cnt_q, sh_cnt_d;
   logic            pc_ld_q;
   logic [PC_W-1:0] pc_target_q;
   logic            shadow_q;
   logic [7:0]      taken_cnt_q;

   logic eff_c, eff_z;
   logic cond_true;
   logic is_uncon;
   logic accept_ok;
   logic redirect;

   always_comb begin
      // A flag write retiring this cycle is not yet architected, so bypass it.
      eff_c     = FLG_LD_WB ? C_WB : C_FLAG;
      eff_z     = FLG_LD_WB ? Z_WB : Z_FLAG;
      cond_true = 1'b0;
      is_uncon  = 1'b0;
      case (BR_TYPE)
         T_BRN, T_CALL, T_RET: is_uncon  = 1'b1;
         T_BREQ:               cond_true = eff_z;
         T_BRNE:               cond_true = ~eff_z;
         T_BRCS:               cond_true = eff_c;
         T_BRCC:               cond_true = ~eff_c;
         T_NONE:               cond_true = 1'b0;
         default:              cond_true = 1'b0;
      endcase
      accept_ok     = BR_VALID && (sh_cnt_q <= 3'd1) && !RESET;
      UNCON_BRN     = accept_ok && is_uncon;
      TAKE_COND_BRN = accept_ok && cond_true;
      redirect      = UNCON_BRN || TAKE_COND_BRN;
      if (redirect)
         sh_cnt_d = 3'd4;
      else if (sh_cnt_q != 3'd0)
         sh_cnt_d = sh_cnt_q - 3'd1;
      else
         sh_cnt_d = 3'd0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         sh_cnt_q    <= 3'd0;
         pc_ld_q     <= 1'b0;
         pc_target_q <= '0;
         shadow_q    <= 1'b0;
         taken_cnt_q <= 8'd0;
      end else begin
         sh_cnt_q <= sh_cnt_d;
         shadow_q <= (sh_cnt_d > 3'd1);
         pc_ld_q  <= redirect;
         if (redirect) begin
            pc_target_q <= (BR_TYPE == T_RET) ? RET_ADDR : BR_TARGET;
            taken_cnt_q <= taken_cnt_q + 8'd1;
         end
         case (state_q)
            IDLE:    state_q <= redirect ? FLUSH : IDLE;
            FLUSH:   state_q <= (sh_cnt_d == 3'd0) ? IDLE : FLUSH;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign PC_LD     = pc_ld_q;
   assign PC_TARGET = pc_target_q;
   assign SHADOW    = shadow_q;
   assign TAKEN_CNT = taken_cnt_q;

endmodule
